// File: rtl/booth_radix4_seq.sv
// Sequential radix-4 (modified) Booth multiplier.
// One Booth digit is retired per clock. Operands are captured on an accepted
// start, the digit stream walks the multiplier two bits at a time, and the
// result is presented on PRODUCT with a single-cycle done pulse.

module booth_radix4_seq #(
  parameter int  WIDTH      = 32,
  parameter int  EARLY_TERM = 1,
  localparam int NDIG       = WIDTH / 2 + 1,
  localparam int CNT_W      = $clog2(NDIG + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic [CNT_W-1:0]   addcnt,
  output logic [CNT_W-1:0]   subcnt
);

  // Multiplier register holds Mx[WIDTH+1:-1]: two extension bits on top and
  // the implicit zero below bit 0, so mx[2:0] is always the current triplet.
  localparam int MW = WIDTH + 3;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [MW-1:0]    mx;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] idx;

  logic             accept;
  logic             sign_a;
  logic             sign_b;
  logic [MW-1:0]    mx_load;
  logic [PW-1:0]    mcand_load;
  logic             dig_pos;
  logic             dig_neg;
  logic             dig_two;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;
  logic             rest_uniform;
  logic             last_digit;

  assign accept = start & ~busy;

  // Extension bits: sign-extend in signed mode, zero-extend otherwise.
  assign sign_a     = is_signed & Multiplicand[WIDTH-1];
  assign sign_b     = is_signed & Multiplier[WIDTH-1];
  assign mx_load    = {sign_b, sign_b, Multiplier, 1'b0};
  assign mcand_load = {{WIDTH{sign_a}}, Multiplicand};

  // Only the low 2*WIDTH bits of the running sum are ever observable, so the
  // accumulator and the shifted multiplicand are kept at that width.
  assign PRODUCT = acc;

  // Decode the current Booth triplet into sign and magnitude (1 or 2).
  always_comb begin
    dig_pos = 1'b0;
    dig_neg = 1'b0;
    dig_two = 1'b0;
    case (mx[2:0])
      3'b001, 3'b010: dig_pos = 1'b1;
      3'b011: begin
        dig_pos = 1'b1;
        dig_two = 1'b1;
      end
      3'b100: begin
        dig_neg = 1'b1;
        dig_two = 1'b1;
      end
      3'b101, 3'b110: dig_neg = 1'b1;
      default: ;
    endcase
  end

  assign addend = dig_two ? {mcand[PW-2:0], 1'b0} : mcand;

  // Apply the decoded digit to the accumulator.
  always_comb begin
    acc_next = acc;
    if (dig_pos)
      acc_next = acc + addend;
    else if (dig_neg)
      acc_next = acc - addend;
  end

  // The register is shifted arithmetically, so mx[MW-1:2] is exactly
  // Mx[WIDTH+1:2i+1]; once it is uniform every later triplet is 000 or 111.
  assign rest_uniform = (&mx[MW-1:2]) | ~(|mx[MW-1:2]);
  assign last_digit   = (idx == CNT_W'(NDIG - 1)) ||
                        ((EARLY_TERM != 0) && rest_uniform);

  // Control FSM and datapath registers; the first RUN cycle only raises busy
  // while the freshly captured operands sit in their registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      addcnt <= '0;
      subcnt <= '0;
      idx    <= '0;
      mx     <= '0;
      mcand  <= '0;
    end else if (accept) begin
      state  <= RUN;
      done   <= 1'b0;
      mx     <= mx_load;
      mcand  <= mcand_load;
      acc    <= '0;
      addcnt <= '0;
      subcnt <= '0;
      idx    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!busy) begin
            busy <= 1'b1;
          end else begin
            acc   <= acc_next;
            mx    <= {{2{mx[MW-1]}}, mx[MW-1:2]};
            mcand <= {mcand[PW-3:0], 2'b00};
            idx   <= idx + CNT_W'(1);
            if (dig_pos)
              addcnt <= addcnt + CNT_W'(1);
            if (dig_neg)
              subcnt <= subcnt + CNT_W'(1);
            if (last_digit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Self-checking bench for booth_radix4_seq.
// Instance 0 uses early termination, instance 1 always runs all digits.
// Stimulus pushes hand-computed results into a per-instance queue; a negedge
// monitor pops and compares whenever an instance pulses done.

module tb_booth_radix4_seq;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef struct {
    string       tag;
    logic [63:0] p;
    int          ad;
    int          sb;
    int          k;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start_s [2];
  logic             sgn_s   [2];
  logic [WIDTH-1:0] mc_s    [2];
  logic [WIDTH-1:0] mp_s    [2];
  logic             busy_s  [2];
  logic             done_s  [2];
  logic [63:0]      prod_s  [2];
  logic [CNT_W-1:0] add_s   [2];
  logic [CNT_W-1:0] sub_s   [2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;

  int nchecks = 0;
  int nfail   = 0;
  int cyc     = 0;
  int acc_cyc [2];
  int busy_cnt[2];
  int ndone   [2];
  int saved_done;

  booth_radix4_seq #(.WIDTH(WIDTH), .EARLY_TERM(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .is_signed(sgn_s[0]),
    .Multiplicand(mc_s[0]), .Multiplier(mp_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .PRODUCT(prod_s[0]), .addcnt(add_s[0]), .subcnt(sub_s[0])
  );

  booth_radix4_seq #(.WIDTH(WIDTH), .EARLY_TERM(0)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .is_signed(sgn_s[1]),
    .Multiplicand(mc_s[1]), .Multiplier(mp_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .PRODUCT(prod_s[1]), .addcnt(add_s[1]), .subcnt(sub_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nchecks++;
    if (act !== req) begin
      nfail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Drive one request at posedge+1; held for exactly one clock, then the
  // operand inputs are scrambled since the DUT must have captured them.
  task automatic applyStimulus(input int u, input string tag, input bit push,
                               input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] p, input int ad, input int sb, input int k);
    exp_t e;
    if (push) begin
      e.tag = tag; e.p = p; e.ad = ad; e.sb = sb; e.k = k;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    start_s[u] = 1'b1;
    sgn_s[u]   = sgn;
    mc_s[u]    = a;
    mp_s[u]    = b;
    @(posedge clk); #1;
    start_s[u] = 1'b0;
    mc_s[u]    = 32'hDEAD_BEEF;
    mp_s[u]    = 32'h1357_9BDF;
    sgn_s[u]   = ~sgn;
  endtask

  task automatic waitDone(input int u, input string tag);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (done_s[u]) return;
    end
    nchecks++;
    nfail++;
    $display("[TB] FAIL %s timeout: got no done in 300 cycles, want done", tag);
  endtask

  task automatic runOp(input int u, input string tag, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] p, input int ad, input int sb, input int k);
    applyStimulus(u, tag, 1'b1, sgn, a, b, p, ad, sb, k);
    waitDone(u, tag);
    @(posedge clk); #1;
    checkOutput({tag, " held"}, prod_s[u], p);
  endtask

  // Monitor: tracks accepts and busy cycles, scores every done pulse.
  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        busy_cnt[u] = 0;
      end else begin
        if (busy_s[u]) busy_cnt[u]++;
        if (done_s[u]) begin
          ndone[u]++;
          if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            nchecks++;
            nfail++;
            $display("[TB] FAIL unexpected_done dut%0d: got done=1, want no pending result", u);
          end else begin
            if (u == 0) mon_e = q0.pop_front();
            else        mon_e = q1.pop_front();
            checkOutput({mon_e.tag, " product"}, prod_s[u], mon_e.p);
            checkOutput({mon_e.tag, " addcnt"}, 64'(add_s[u]), 64'(mon_e.ad));
            checkOutput({mon_e.tag, " subcnt"}, 64'(sub_s[u]), 64'(mon_e.sb));
            checkOutput({mon_e.tag, " latency"}, 64'(cyc - acc_cyc[u] - 1), 64'(mon_e.k + 1));
            checkOutput({mon_e.tag, " busy_cycles"}, 64'(busy_cnt[u]), 64'(mon_e.k));
          end
        end
        if (start_s[u] && !busy_s[u]) begin
          acc_cyc[u]  = cyc;
          busy_cnt[u] = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; sgn_s[u] = 1'b0; mc_s[u] = '0; mp_s[u] = '0;
      acc_cyc[u] = 0; busy_cnt[u] = 0; ndone[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy",    64'(busy_s[0]), 64'd0);
    checkOutput("reset done",    64'(done_s[0]), 64'd0);
    checkOutput("reset product", prod_s[0], 64'd0);
    checkOutput("reset addcnt",  64'(add_s[0]), 64'd0);
    checkOutput("reset subcnt",  64'(sub_s[0]), 64'd0);
    checkOutput("reset product et0", prod_s[1], 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Early-terminating instance: directed vectors.
    runOp(0, "s 7*-3",       1'b1, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1, 1, 2);
    runOp(0, "s 12345*0",    1'b1, 32'd12345,      32'd0,         64'h0,                   0, 0, 1);
    runOp(0, "u ffff*ffff",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1, 1, 17);
    runOp(0, "s min*min",    1'b1, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000, 0, 1, 16);
    runOp(0, "s -1*-1",      1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h1,                   0, 1, 1);
    runOp(0, "u 5*3",        1'b0, 32'd5,          32'd3,         64'd15,                  1, 1, 2);
    runOp(0, "s 100*2",      1'b1, 32'd100,        32'd2,         64'd200,                 1, 1, 2);
    runOp(0, "u 3*msb",      1'b0, 32'd3,          32'h8000_0000, 64'h0000_0001_8000_0000, 1, 1, 17);
    runOp(0, "s -3*7",       1'b1, 32'hFFFF_FFFD,  32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1, 1, 2);

    // A start pulse while busy must not disturb the running operation.
    applyStimulus(0, "u ffff*ffff busy", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  64'hFFFF_FFFE_0000_0001, 1, 1, 17);
    repeat (5) @(posedge clk);
    #1;
    start_s[0] = 1'b1; sgn_s[0] = 1'b1; mc_s[0] = 32'd2; mp_s[0] = 32'd3;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    waitDone(0, "u ffff*ffff busy");
    @(posedge clk); #1;

    // Reset in the middle of an operation aborts it with no done pulse.
    applyStimulus(0, "abort", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort busy",    64'(busy_s[0]), 64'd0);
    checkOutput("abort done",    64'(done_s[0]), 64'd0);
    checkOutput("abort product", prod_s[0], 64'd0);
    checkOutput("abort addcnt",  64'(add_s[0]), 64'd0);
    checkOutput("abort subcnt",  64'(sub_s[0]), 64'd0);
    saved_done = ndone[0];
    repeat (30) @(posedge clk);
    #1;
    checkOutput("abort no_done", 64'(ndone[0]), 64'(saved_done));

    // Full-length instance, plus a start accepted during the done cycle.
    runOp(1, "et0 7*-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1, 1, 17);
    applyStimulus(1, "et0 b2b first", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD,
                  64'hFFFF_FFFF_FFFF_FFEB, 1, 1, 17);
    waitDone(1, "et0 b2b first");
    applyStimulus(1, "et0 b2b second", 1'b1, 1'b1, 32'd12345, 32'd0, 64'h0, 0, 0, 17);
    waitDone(1, "et0 b2b second");

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queue0 drained", 64'(q0.size()), 64'd0);
    checkOutput("queue1 drained", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
